// File: rtl/can_rx_pkg.sv
// Shared constants and helpers for the CAN receive buffer: register map, command bits and
// the frame-length rule derived from the PeliCAN frame-info byte.
package can_rx_pkg;

    localparam logic [7:0] RegCmd     = 8'd1;
    localparam logic [7:0] RegSr      = 8'd2;
    localparam logic [7:0] RegRxWinLo = 8'd16;
    localparam logic [7:0] RegRxWinHi = 8'd28;
    localparam logic [7:0] RegRmc     = 8'd29;
    localparam logic [7:0] RegRbsa    = 8'd30;

    localparam int unsigned CmdRrbBit = 2;
    localparam int unsigned CmdCdoBit = 3;

    typedef struct packed {
        logic       ff;
        logic       rtr;
        logic [1:0] rsvd;
        logic [3:0] dlc;
    } frame_info_t;

    // Bytes occupied in the FIFO by a frame: info + identifier + data (DLC capped at 8).
    function automatic logic [3:0] frame_len(input logic [7:0] info);
        frame_info_t fi;
        logic [3:0]  data_len;
        fi = frame_info_t'(info);
        if (fi.rtr) begin
            data_len = 4'd0;
        end else if (fi.dlc > 4'd8) begin
            data_len = 4'd8;
        end else begin
            data_len = fi.dlc;
        end
        return 4'd1 + (fi.ff ? 4'd4 : 4'd2) + data_len;
    endfunction

endpackage

// File: rtl/can_rx_mem.sv
// Byte-wide receive FIFO storage: one synchronous write port and two asynchronous read
// ports (register window and head-of-queue frame info).
module can_rx_mem #(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [7:0]    rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [7:0]    rdata_b_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/can_rx_buffer.sv
// CAN receive buffer: circular byte FIFO of completed frames with commit/abort of the frame
// in progress, release-buffer and clear-overrun commands, and the receive register window.
module can_rx_buffer
    import can_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic       aclk,
    input  logic       arstn,
    input  logic       reg_re_i,
    input  logic       reg_we_i,
    input  logic [7:0] reg_addr_read_i,
    input  logic [7:0] reg_addr_write_i,
    input  logic [7:0] reg_data_in_i,
    output logic [7:0] reg_data_out_o,
    input  logic       rx_we_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_done_i,
    input  logic       rx_abort_i,
    output logic       rbs_o,
    output logic       dos_o,
    output logic [6:0] rmc_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] tmp_ptr_q, tmp_ptr_d;
    logic [CW-1:0] used_q, used_d;
    logic [CW-1:0] tmp_cnt_q, tmp_cnt_d;
    logic [6:0]    rmc_q, rmc_d;
    logic          dos_q, dos_d;
    logic          ovf_frame_q, ovf_frame_d;

    logic          cmd_we;
    logic          rrb;
    logic          cdo;
    logic          mem_we;
    logic          commit;
    logic          rbs;
    logic [AW-1:0] win_addr;
    logic [7:0]    win_data;
    logic [7:0]    head_info;
    logic          unused_inputs;

    assign cmd_we = reg_we_i && (reg_addr_write_i == RegCmd);
    assign rrb    = cmd_we && reg_data_in_i[CmdRrbBit] && (rmc_q != 7'd0);
    assign cdo    = cmd_we && reg_data_in_i[CmdCdoBit];
    assign rbs    = (rmc_q != 7'd0);

    // Reads are side-effect free, so the read strobe and the unused command bits are dropped.
    assign unused_inputs = ^{reg_re_i, reg_data_in_i[7:4], reg_data_in_i[1:0]};

    assign win_addr = rd_ptr_q + AW'(reg_addr_read_i - RegRxWinLo);

    can_rx_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_i    (aclk),
        .we_i     (mem_we),
        .waddr_i  (tmp_ptr_q),
        .wdata_i  (rx_data_i),
        .raddr_a_i(win_addr),
        .rdata_a_o(win_data),
        .raddr_b_i(rd_ptr_q),
        .rdata_b_o(head_info)
    );

    // Ordering within a cycle: release first (frees space), then the byte write, then
    // commit/abort of the frame in progress.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        tmp_ptr_d   = tmp_ptr_q;
        used_d      = used_q;
        tmp_cnt_d   = tmp_cnt_q;
        dos_d       = dos_q;
        ovf_frame_d = ovf_frame_q;
        mem_we      = 1'b0;
        commit      = 1'b0;

        if (rrb) begin
            rd_ptr_d = rd_ptr_q + AW'(frame_len(head_info));
            used_d   = used_q - CW'(frame_len(head_info));
        end

        if (cdo) begin
            dos_d = 1'b0;
        end

        if (rx_we_i && !ovf_frame_q) begin
            if ((used_d + tmp_cnt_q) < CW'(DEPTH)) begin
                mem_we    = 1'b1;
                tmp_ptr_d = tmp_ptr_q + AW'(1);
                tmp_cnt_d = tmp_cnt_q + CW'(1);
            end else begin
                dos_d       = 1'b1;
                ovf_frame_d = 1'b1;
                tmp_ptr_d   = wr_ptr_q;
                tmp_cnt_d   = '0;
            end
        end

        if (rx_abort_i) begin
            tmp_ptr_d   = wr_ptr_q;
            tmp_cnt_d   = '0;
            ovf_frame_d = 1'b0;
        end else if (rx_done_i) begin
            if (!ovf_frame_d && (tmp_cnt_d != '0)) begin
                wr_ptr_d = tmp_ptr_d;
                used_d   = used_d + tmp_cnt_d;
                commit   = 1'b1;
            end
            tmp_cnt_d   = '0;
            ovf_frame_d = 1'b0;
        end

        rmc_d = rmc_q + 7'(commit) - 7'(rrb);
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            tmp_ptr_q   <= '0;
            used_q      <= '0;
            tmp_cnt_q   <= '0;
            rmc_q       <= '0;
            dos_q       <= 1'b0;
            ovf_frame_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            tmp_ptr_q   <= tmp_ptr_d;
            used_q      <= used_d;
            tmp_cnt_q   <= tmp_cnt_d;
            rmc_q       <= rmc_d;
            dos_q       <= dos_d;
            ovf_frame_q <= ovf_frame_d;
        end
    end

    always_comb begin
        reg_data_out_o = 8'h00;
        if ((reg_addr_read_i >= RegRxWinLo) && (reg_addr_read_i <= RegRxWinHi)) begin
            reg_data_out_o = win_data;
        end else begin
            case (reg_addr_read_i)
                RegSr:   reg_data_out_o = {6'b0, dos_q, rbs};
                RegRmc:  reg_data_out_o = {1'b0, rmc_q};
                RegRbsa: reg_data_out_o = 8'(rd_ptr_q);
                default: reg_data_out_o = 8'h00;
            endcase
        end
    end

    assign rbs_o = rbs;
    assign dos_o = dos_q;
    assign rmc_o = rmc_q;

    // Committed plus in-progress bytes can never exceed the FIFO.
    used_bound_a: assert property (@(posedge aclk) disable iff (!arstn)
        ((CW + 1)'(used_q) + (CW + 1)'(tmp_cnt_q)) <= (CW + 1)'(DEPTH));

endmodule

// File: tb/tb_can_rx_buffer.sv
// Self-checking bench for can_rx_buffer: directed scenarios plus randomized frame traffic
// checked against a queue-based model of committed frames.
module tb_can_rx_buffer;

    localparam int DEPTH = 64;

    logic       aclk = 1'b0;
    logic       arstn = 1'b0;
    logic       reg_re_i = 1'b0;
    logic       reg_we_i = 1'b0;
    logic [7:0] reg_addr_read_i = 8'h00;
    logic [7:0] reg_addr_write_i = 8'h00;
    logic [7:0] reg_data_in_i = 8'h00;
    logic [7:0] reg_data_out_o;
    logic       rx_we_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_done_i = 1'b0;
    logic       rx_abort_i = 1'b0;
    logic       rbs_o;
    logic       dos_o;
    logic [6:0] rmc_o;

    always #5 aclk = ~aclk;

    can_rx_buffer #(
        .DEPTH(DEPTH)
    ) dut (
        .aclk            (aclk),
        .arstn           (arstn),
        .reg_re_i        (reg_re_i),
        .reg_we_i        (reg_we_i),
        .reg_addr_read_i (reg_addr_read_i),
        .reg_addr_write_i(reg_addr_write_i),
        .reg_data_in_i   (reg_data_in_i),
        .reg_data_out_o  (reg_data_out_o),
        .rx_we_i         (rx_we_i),
        .rx_data_i       (rx_data_i),
        .rx_done_i       (rx_done_i),
        .rx_abort_i      (rx_abort_i),
        .rbs_o           (rbs_o),
        .dos_o           (dos_o),
        .rmc_o           (rmc_o)
    );

    int total = 0;
    int bad = 0;

    // Model: committed bytes in arrival order, lengths of committed frames, frame in progress.
    logic [7:0] m_bytes[$];
    int         m_len[$];
    logic [7:0] m_pend[$];
    int         m_rd;
    bit         m_dos;
    bit         m_ovf;
    logic [7:0] tx[$];

    function automatic int flen(input logic [7:0] info);
        int d;
        d = int'(info[3:0]);
        if (d > 8) d = 8;
        if (info[6]) d = 0;
        return 1 + (info[7] ? 4 : 2) + d;
    endfunction

    function automatic void model_reset();
        m_bytes.delete();
        m_len.delete();
        m_pend.delete();
        m_rd = 0;
        m_dos = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_step(input bit we, input logic [7:0] d, input bit done,
                                       input bit abort, input logic [7:0] cwa, input bit cwe,
                                       input logic [7:0] cd);
        if (cwe && cwa == 8'd1) begin
            if (cd[2] && m_len.size() > 0) begin
                int l;
                l = m_len.pop_front();
                repeat (l) void'(m_bytes.pop_front());
                m_rd = (m_rd + l) % DEPTH;
            end
            if (cd[3]) m_dos = 0;
        end
        if (we && !m_ovf) begin
            if (m_bytes.size() + m_pend.size() < DEPTH) begin
                m_pend.push_back(d);
            end else begin
                m_dos = 1;
                m_ovf = 1;
                m_pend.delete();
            end
        end
        if (abort) begin
            m_pend.delete();
            m_ovf = 0;
        end else if (done) begin
            if (!m_ovf && m_pend.size() > 0) begin
                m_len.push_back(flen(m_pend[0]));
                foreach (m_pend[i]) m_bytes.push_back(m_pend[i]);
            end
            m_pend.delete();
            m_ovf = 0;
        end
    endfunction

    task automatic clr();
        rx_we_i = 1'b0;
        rx_done_i = 1'b0;
        rx_abort_i = 1'b0;
        reg_we_i = 1'b0;
    endtask

    task automatic drive(input bit we, input logic [7:0] d, input bit done, input bit abort,
                         input logic [7:0] cwa, input bit cwe, input logic [7:0] cd);
        @(negedge aclk);
        rx_we_i = we;
        rx_data_i = d;
        rx_done_i = done;
        rx_abort_i = abort;
        reg_we_i = cwe;
        reg_addr_write_i = cwa;
        reg_data_in_i = cd;
        reg_re_i = ~reg_re_i;
        model_step(we, d, done, abort, cwa, cwe, cd);
    endtask

    task automatic settle();
        @(negedge aclk);
        clr();
        #1;
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
        @(negedge aclk);
        clr();
        reg_addr_read_i = a;
        #1;
        v = reg_data_out_o;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        arstn = 1'b0;
        clr();
        model_reset();
        @(negedge aclk);
        arstn = 1'b1;
    endtask

    // Sends tx[], commit either with the last byte or on a separate cycle.
    task automatic send_tx(input bit done_last);
        for (int i = 0; i < tx.size(); i++) begin
            drive(1'b1, tx[i], done_last && (i == tx.size() - 1), 1'b0, 8'd1, 1'b0, 8'h00);
        end
        if (!done_last) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'd1, 1'b0, 8'h00);
    endtask

    task automatic make_tx(input logic [7:0] info);
        tx.delete();
        tx.push_back(info);
        for (int i = 1; i < flen(info); i++) tx.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        logic [7:0] v;
        repeat (2) @(negedge aclk);
        #1;
        total++;
        if (rmc_o !== 7'd0 || rbs_o !== 1'b0 || dos_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got rmc=%0d rbs=%b dos=%b want 0 0 0", rmc_o, rbs_o, dos_o);
        end
        @(negedge aclk);
        arstn = 1'b1;
        rd_reg(8'd2, v);
        total++;
        if (v !== 8'h00) begin bad++; $display("FAIL reset_sr got=%h want=00", v); end
        rd_reg(8'd29, v);
        total++;
        if (v !== 8'h00) begin bad++; $display("FAIL reset_rmc_reg got=%h want=00", v); end
        rd_reg(8'd30, v);
        total++;
        if (v !== 8'h00) begin bad++; $display("FAIL reset_rbsa got=%h want=00", v); end
        rd_reg(8'd31, v);
        total++;
        if (v !== 8'h00) begin bad++; $display("FAIL reset_unmapped got=%h want=00", v); end
    endtask

    task automatic test_basic();
        logic [7:0] v;
        logic [7:0] exp [11] = '{8'h08, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                 8'h06, 8'h07, 8'h08};
        do_reset();
        tx.delete();
        foreach (exp[i]) tx.push_back(exp[i]);
        send_tx(1'b0);
        settle();
        total++;
        if (rmc_o !== 7'd1 || rbs_o !== 1'b1) begin
            bad++;
            $display("FAIL basic_commit got rmc=%0d rbs=%b want 1 1", rmc_o, rbs_o);
        end
        for (int k = 0; k < 11; k++) begin
            rd_reg(8'(16 + k), v);
            total++;
            if (v !== exp[k]) begin bad++; $display("FAIL basic_win%0d got=%h want=%h", k, v, exp[k]); end
        end
        rd_reg(8'd2, v);
        total++;
        if (v !== 8'h01) begin bad++; $display("FAIL basic_sr got=%h want=01", v); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b1, 8'h04);
        settle();
        total++;
        if (rmc_o !== 7'd0 || rbs_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_release got rmc=%0d rbs=%b want 0 0", rmc_o, rbs_o);
        end
        rd_reg(8'd30, v);
        total++;
        if (v !== 8'd11) begin bad++; $display("FAIL basic_rbsa got=%0d want=11", v); end
    endtask

    task automatic test_overrun();
        logic [7:0] v;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            make_tx(8'h88);
            send_tx(1'b1);
        end
        settle();
        total++;
        if (dos_o !== 1'b1 || rmc_o !== 7'd4) begin
            bad++;
            $display("FAIL overrun got dos=%b rmc=%0d want 1 4", dos_o, rmc_o);
        end
        // Command bits written to a non-command index must be ignored.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b1, 8'h0c);
        settle();
        total++;
        if (dos_o !== 1'b1 || rmc_o !== 7'd4) begin
            bad++;
            $display("FAIL overrun_wrong_idx got dos=%b rmc=%0d want 1 4", dos_o, rmc_o);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b1, 8'h08);
        settle();
        total++;
        if (dos_o !== 1'b0 || rmc_o !== 7'd4) begin
            bad++;
            $display("FAIL overrun_cdo got dos=%b rmc=%0d want 0 4", dos_o, rmc_o);
        end
        rd_reg(8'd2, v);
        total++;
        if (v !== 8'h01) begin bad++; $display("FAIL overrun_sr got=%h want=01", v); end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        logic [7:0] infos [5] = '{8'h88, 8'h88, 8'h88, 8'h88, 8'h83};
        do_reset();
        foreach (infos[i]) begin
            make_tx(infos[i]);
            send_tx(1'b1);
            drive(1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b1, 8'h04);
        end
        rd_reg(8'd30, v);
        total++;
        if (v !== 8'd60) begin bad++; $display("FAIL wrap_rbsa got=%0d want=60", v); end
        make_tx(8'h88);
        send_tx(1'b0);
        settle();
        total++;
        if (rmc_o !== 7'd1) begin bad++; $display("FAIL wrap_rmc got=%0d want=1", rmc_o); end
        for (int k = 0; k < 13; k++) begin
            rd_reg(8'(16 + k), v);
            total++;
            if (v !== tx[k]) begin bad++; $display("FAIL wrap_win%0d got=%h want=%h", k, v, tx[k]); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b1, 8'h04);
        rd_reg(8'd30, v);
        total++;
        if (v !== 8'd9) begin bad++; $display("FAIL wrap_rbsa_after got=%0d want=9", v); end
    endtask

    task automatic test_abort();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 8'd1, 1'b0, 8'h00);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd1, 1'b0, 8'h00);
        make_tx(8'hc3);
        send_tx(1'b0);
        settle();
        total++;
        if (rmc_o !== 7'd1) begin bad++; $display("FAIL abort_rmc got=%0d want=1", rmc_o); end
        for (int k = 0; k < 5; k++) begin
            rd_reg(8'(16 + k), v);
            total++;
            if (v !== tx[k]) begin bad++; $display("FAIL abort_win%0d got=%h want=%h", k, v, tx[k]); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b1, 8'h04);
        rd_reg(8'd30, v);
        total++;
        if (v !== 8'd5) begin bad++; $display("FAIL abort_rbsa got=%0d want=5", v); end
    endtask

    task automatic test_commit_rrb();
        logic [7:0] v;
        do_reset();
        make_tx(8'h08);
        send_tx(1'b1);
        make_tx(8'h02);
        send_tx(1'b1);
        make_tx(8'h01);
        for (int i = 0; i < 3; i++) drive(1'b1, tx[i], 1'b0, 1'b0, 8'd1, 1'b0, 8'h00);
        drive(1'b1, tx[3], 1'b1, 1'b0, 8'd1, 1'b1, 8'h04);
        settle();
        total++;
        if (rmc_o !== 7'd2) begin bad++; $display("FAIL cmrrb_rmc got=%0d want=2", rmc_o); end
        rd_reg(8'd30, v);
        total++;
        if (v !== 8'd11) begin bad++; $display("FAIL cmrrb_rbsa got=%0d want=11", v); end
        rd_reg(8'd16, v);
        total++;
        if (v !== 8'h02) begin bad++; $display("FAIL cmrrb_head got=%h want=02", v); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b1, 8'h04);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b1, 8'h04);
        rd_reg(8'd30, v);
        total++;
        if (v !== 8'd20 || rmc_o !== 7'd0) begin
            bad++;
            $display("FAIL cmrrb_drain got rbsa=%0d rmc=%0d want 20 0", v, rmc_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            make_tx(8'h00);
            send_tx(1'b1);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 8'd1, 1'b0, 8'h00);
        settle();
        total++;
        if (rmc_o !== 7'd3) begin bad++; $display("FAIL rstmid_pre got=%0d want=3", rmc_o); end
        @(negedge aclk);
        arstn = 1'b0;
        model_reset();
        reg_addr_read_i = 8'd2;
        #1;
        total++;
        if (rmc_o !== 7'd0 || rbs_o !== 1'b0 || dos_o !== 1'b0 || reg_data_out_o !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_outputs got rmc=%0d rbs=%b dos=%b sr=%h want 0 0 0 00",
                     rmc_o, rbs_o, dos_o, reg_data_out_o);
        end
        reg_addr_read_i = 8'd30;
        #1;
        total++;
        if (reg_data_out_o !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_rbsa got=%h want=00", reg_data_out_o);
        end
        @(negedge aclk);
        arstn = 1'b1;
        make_tx(8'h02);
        send_tx(1'b1);
        settle();
        total++;
        if (rmc_o !== 7'd1) begin bad++; $display("FAIL rstmid_after got=%0d want=1", rmc_o); end
        for (int k = 0; k < 5; k++) begin
            rd_reg(8'(16 + k), v);
            total++;
            if (v !== tx[k]) begin bad++; $display("FAIL rstmid_win%0d got=%h want=%h", k, v, tx[k]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [7:0] info;
        int         rrb_pct;
        int         ab;
        bit         dl;
        bit         r;
        int         hl;
        do_reset();
        rrb_pct = 5;
        for (int f = 0; f < 240; f++) begin
            if (f % 20 == 0) rrb_pct = (f % 40 == 0) ? 5 : 45;
            info = 8'($urandom);
            make_tx(info);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, tx.size() - 1) : -1;
            dl = $urandom_range(0, 1) == 1;
            for (int i = 0; i < tx.size(); i++) begin
                if (i == ab) begin
                    drive(1'b0, 8'h00, $urandom_range(0, 1) == 1, 1'b1, 8'd1, 1'b0, 8'h00);
                    break;
                end
                r = $urandom_range(0, 99) < rrb_pct;
                drive(1'b1, tx[i], dl && (i == tx.size() - 1), 1'b0, 8'd1, r, 8'h04);
            end
            if (ab < 0 && !dl) begin
                r = $urandom_range(0, 99) < rrb_pct;
                drive(1'b0, 8'h00, 1'b1, 1'b0, ($urandom_range(0, 3) == 0) ? 8'd2 : 8'd1, r, 8'h04);
            end
            if ($urandom_range(0, 7) == 0) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b1, 8'h08);
            settle();
            total++;
            if (rmc_o !== 7'(m_len.size()) || rbs_o !== (m_len.size() != 0) || dos_o !== m_dos) begin
                bad++;
                $display("FAIL rand%0d_status got rmc=%0d rbs=%b dos=%b want %0d %b %b", f, rmc_o,
                         rbs_o, dos_o, m_len.size(), m_len.size() != 0, m_dos);
            end
            rd_reg(8'd30, v);
            total++;
            if (v !== 8'(m_rd)) begin bad++; $display("FAIL rand%0d_rbsa got=%0d want=%0d", f, v, m_rd); end
            if (m_len.size() > 0) begin
                hl = m_len[0];
                for (int k = 0; k < hl; k++) begin
                    rd_reg(8'(16 + k), v);
                    total++;
                    if (v !== m_bytes[k]) begin
                        bad++;
                        $display("FAIL rand%0d_win%0d got=%h want=%h", f, k, v, m_bytes[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overrun();
        test_wrap();
        test_abort();
        test_commit_rrb();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/can_rx_buffer.md
# can_rx_buffer

Receive-buffer stage of the CAN controller register space, directly downstream of the APB register adapter. It holds completed received frames in a 64-byte circular FIFO (PeliCAN layout), exposes the oldest frame through the receive-buffer register window, and implements the release-buffer and clear-overrun commands. Frames are supplied byte by byte from the bit-stream processor and committed or discarded at end-of-frame.

## Interface
- `DEPTH`, 64, FIFO size in bytes; power of two, 32..256
- `aclk`  in  1  clock
- `arstn`  in  1  asynchronous, active-low reset
- `reg_re_i`  in  1  register read strobe from the APB adapter
- `reg_we_i`  in  1  register write strobe, one cycle per APB write
- `reg_addr_read_i`  in  8  read register index
- `reg_addr_write_i`  in  8  write register index
- `reg_data_in_i`  in  8  write data
- `reg_data_out_o`  out  8  read data; combinational from `reg_addr_read_i`
- `rx_we_i`  in  1  one received byte valid this cycle
- `rx_data_i`  in  8  received byte; first byte of each frame is frame info
- `rx_done_i`  in  1  frame received correctly: commit
- `rx_abort_i`  in  1  frame error: discard
- `rbs_o`  out  1  receive buffer status (RMC ≠ 0)
- `dos_o`  out  1  data overrun status
- `rmc_o`  out  7  receive message counter

## Operation
- Frame info byte: bit7 FF (extended), bit6 RTR, bits3:0 DLC.
- Frame length: 1 + (FF ? 4 : 2) + (RTR ? 0 : min(DLC, 8)); range 3..13.
- State: `rd_ptr`, `wr_ptr` (committed), `tmp_ptr` (in-progress frame), `used` (committed bytes, 0..DEPTH), `tmp_cnt`, `rmc`, `dos`, `ovf_frame` flag.
- Write path: on `rx_we_i`, if `!ovf_frame` and `used + tmp_cnt < DEPTH`, write the byte at `tmp_ptr`, then increment `tmp_ptr` and `tmp_cnt`. If the FIFO is full, set `dos` and `ovf_frame`, restore `tmp_ptr` to `wr_ptr`, clear `tmp_cnt`, and drop the remaining bytes of the frame.
- `rx_done_i`: if `!ovf_frame` and `tmp_cnt > 0`, set `wr_ptr` = `tmp_ptr`, `used` += `tmp_cnt`, and `rmc` += 1. In every case clear `tmp_cnt` and `ovf_frame`. `rx_abort_i` restores `tmp_ptr` to `wr_ptr` and clears `tmp_cnt` and `ovf_frame`. Abort wins if both are asserted.
- Command register, index 1, written with `reg_we_i`:
  - bit2 RRB: if `rmc > 0`, advance `rd_ptr` by the length of the frame at `rd_ptr` (mod DEPTH), subtract that length from `used`, and decrement `rmc`. Ignored when `rmc = 0`.
  - bit3 CDO: clear `dos`.
- Read map:
  - index 2: status {6'b0, `dos`, `rbs`}.
  - indices 16..28: `mem[(rd_ptr + idx − 16) mod DEPTH]`. Contents are stale when `rmc = 0`.
  - index 29: {1'b0, `rmc`}.
  - index 30: `rd_ptr` zero-extended to 8 bits.
  - all other indices: 0x00.
- Reads have no side effects. `reg_re_i` is ignored by the logic.
- All pointer arithmetic is modulo DEPTH, so wrap-around is implicit.

## Timing
- Reset values: `rd_ptr` = `wr_ptr` = `tmp_ptr` = 0; `used` = `tmp_cnt` = `rmc` = 0; `dos` = 0; `rbs_o` = 0; `dos_o` = 0; `rmc_o` = 0; `reg_data_out_o` = the read-map value of the current address. Memory contents are not reset.
- Reset asserted mid-frame or mid-command aborts everything immediately.
- A committed frame is visible at the window on the cycle after `rx_done_i`. `rbs_o` rises on that same cycle.
- RRB takes effect on the cycle after `reg_we_i`. Window reads return the next frame from that cycle on.
- Commit and RRB in the same cycle: `rmc` is unchanged; `used` = `used` + `tmp_cnt` − len.
- Bytes freed by an RRB are available to a write in the same cycle; the full check uses the post-release `used`.
- `rx_we_i` together with `rx_done_i` in the same cycle: the byte is written first and included in the commit.
- `rmc` never exceeds DEPTH/3. No saturation logic is needed.

## Structure
- Package `can_rx_pkg`:
  - register index constants (CMD=1, SR=2, RXWIN_LO=16, RXWIN_HI=28, RMC=29, RBSA=30)
  - command bit positions
  - the `frame_len(info)` function
- Sub-module `can_rx_mem`: DEPTH×8 RAM with synchronous write and asynchronous read. It needs two read ports: the register window and the frame-info byte at `rd_ptr`.

## Test plan
- Standard data frame, info 0x08, id 0x12 0x34, data 0x01..0x08, then `rx_done_i`:
  - `rmc_o` = 1, `rbs_o` = 1
  - reads of 16..28 return 0x08, 0x12, 0x34, 0x01..0x08
  - write 0x04 to index 1 gives `rmc_o` = 0, index 30 reads 11
- Fill with five 13-byte frames, then send a sixth: `dos_o` = 1, `rmc_o` = 4, and the fifth frame is dropped once used reaches 64. Write 0x08 to index 1: `dos_o` = 0.
- Wrap-around: release frames until `rd_ptr` = 60, then commit a 13-byte frame. The window reads the bytes in order across index 63→0.
- Abort mid-frame after 5 bytes, then send a valid RTR extended frame, info 0xC3 (length 5): only the second frame is stored and `rmc_o` = 1.
- Commit and RRB in the same cycle with `rmc` = 2: `rmc_o` stays 2 and index 30 advances by the released frame's length.
- Assert `arstn` low mid-frame with `rmc` = 3: all outputs return to reset values, and index 2 reads 0x00.
